// File: rtl/column_rx_if.sv
// column_rx_if: serial column-select bus plus the decoded column outputs.
// The master side drives the serial pins and the slave side decodes them.
interface column_rx_if #(
    parameter int SPI_SIZE = 8,
    parameter int NUM_COLS = 16
);
    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    // Asynchronous serial pins
    logic                ser_clk;
    logic                ser_data;
    logic                ser_stcp;
    logic                ser_n_enable;

    // Decoded column state
    logic [SPI_SIZE-1:0] col_q;
    logic                col_strobe;
    logic [IDX_W-1:0]    col_idx;
    logic                col_idx_valid;
    logic                extra_bit;
    logic                out_en;
    logic                frame_err;
    logic [7:0]          err_cnt;

    modport master (
        output ser_clk, ser_data, ser_stcp, ser_n_enable,
        input  col_q, col_strobe, col_idx, col_idx_valid,
        input  extra_bit, out_en, frame_err, err_cnt
    );

    modport slave (
        input  ser_clk, ser_data, ser_stcp, ser_n_enable,
        output col_q, col_strobe, col_idx, col_idx_valid,
        output extra_bit, out_en, frame_err, err_cnt
    );
endinterface

// File: rtl/column_rx.sv
// column_rx: receives a shift-register style serial stream (clock, data,
// storage latch, active-low enable), latches frames into col_q and tracks
// which matrix column is currently selected.
// Optional frame-length checking is enabled by defining COLUMN_RX_ERR_EN.
module column_rx #(
    parameter int SPI_SIZE    = 8,
    parameter int NUM_COLS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    column_rx_if.slave  rx
);

    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CNT_W = $clog2(2 * SPI_SIZE);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * SPI_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SPI_SIZE);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_COLS - 1);

    // Synchronizer channel positions
    localparam int CH_CLK  = 0;
    localparam int CH_DATA = 1;
    localparam int CH_STCP = 2;
    localparam int CH_EN   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [3:0] sync_q [SYNC_STAGES];

    logic ser_clk_s;
    logic ser_data_s;
    logic ser_stcp_s;
    logic en_s;

    // Shift every serial pin through SYNC_STAGES flops. The enable is
    // inverted before synchronizing so a cleared chain means outputs off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {~rx.ser_n_enable, rx.ser_stcp, rx.ser_data, rx.ser_clk};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign ser_clk_s  = sync_q[SYNC_STAGES-1][CH_CLK];
    assign ser_data_s = sync_q[SYNC_STAGES-1][CH_DATA];
    assign ser_stcp_s = sync_q[SYNC_STAGES-1][CH_STCP];
    assign en_s       = sync_q[SYNC_STAGES-1][CH_EN];

    // ------------------------------------------------------------------
    // Edge detection on synchronized strobes
    // ------------------------------------------------------------------
    logic clk_prev_q;
    logic stcp_prev_q;
    logic clk_rise;
    logic stcp_rise;

    // Remember last synchronized level of ser_clk and ser_stcp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_prev_q  <= 1'b0;
            stcp_prev_q <= 1'b0;
        end else begin
            clk_prev_q  <= ser_clk_s;
            stcp_prev_q <= ser_stcp_s;
        end
    end

    assign clk_rise  = ser_clk_s  & ~clk_prev_q;
    assign stcp_rise = ser_stcp_s & ~stcp_prev_q;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   latch_go;

    // A latch request is only taken outside the one-cycle latch state.
    assign latch_go = stcp_rise && (state_q != S_LATCH);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (latch_go) begin
                    state_d = S_LATCH;
                end else if (clk_rise) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (latch_go) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = clk_rise ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register, bit counter, storage register, column index
    // ------------------------------------------------------------------
    logic [SPI_SIZE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    cnt_shift;
    logic [SPI_SIZE-1:0] col_q_q, col_q_d;
    logic [IDX_W-1:0]    col_idx_q, col_idx_d;
    logic                col_idx_valid_q, col_idx_valid_d;
    logic                col_strobe_q;

    // Datapath next-state. The shift is evaluated before the latch so a
    // coincident ser_clk/ser_stcp pair stores the post-shift frame.
    always_comb begin
        shift_d         = shift_q;
        cnt_shift       = bit_cnt_q;
        col_q_d         = col_q_q;
        col_idx_d       = col_idx_q;
        col_idx_valid_d = col_idx_valid_q;

        if (clk_rise) begin
            shift_d = {shift_q[SPI_SIZE-2:0], ser_data_s};
            if (bit_cnt_q != CNT_MAX) begin
                cnt_shift = bit_cnt_q + 1'b1;
            end
        end

        bit_cnt_d = latch_go ? '0 : cnt_shift;

        if (latch_go) begin
            col_q_d = shift_d;
            if (!shift_d[0]) begin
                // Active-low select on bit 0 marks the first column
                col_idx_d       = '0;
                col_idx_valid_d = 1'b1;
            end else if (col_idx_valid_q) begin
                col_idx_d = (col_idx_q == IDX_MAX) ? '0 : col_idx_q + 1'b1;
            end else begin
                col_idx_d = '0;
            end
        end
    end

    // Datapath registers; strobe is high for the cycle after S_LATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            col_q_q         <= '0;
            col_idx_q       <= '0;
            col_idx_valid_q <= 1'b0;
            col_strobe_q    <= 1'b0;
        end else begin
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            col_q_q         <= col_q_d;
            col_idx_q       <= col_idx_d;
            col_idx_valid_q <= col_idx_valid_d;
            col_strobe_q    <= (state_q == S_LATCH);
        end
    end

    // ------------------------------------------------------------------
    // Frame-length checking
    // ------------------------------------------------------------------
`ifdef COLUMN_RX_ERR_EN
    logic       err_pend_q, err_pend_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Capture frame length at latch time, report it alongside col_strobe.
    always_comb begin
        err_pend_d  = err_pend_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (latch_go) begin
            err_pend_d = (cnt_shift != CNT_FULL);
        end
        if ((state_q == S_LATCH) && err_pend_q) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pend_q  <= err_pend_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rx.frame_err = frame_err_q;
    assign rx.err_cnt   = err_cnt_q;
`else
    assign rx.frame_err = 1'b0;
    assign rx.err_cnt   = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx.col_q         = col_q_q;
    assign rx.col_strobe    = col_strobe_q;
    assign rx.col_idx       = col_idx_q;
    assign rx.col_idx_valid = col_idx_valid_q;
    assign rx.extra_bit     = col_q_q[1];
    assign rx.out_en        = en_s;

endmodule

// File: doc/column_rx.md
COLUMN_RX -- requirements
Module: column_rx

Interface
REQ-001 The module SHALL have parameter SPI_SIZE, default 8, meaning bits per serial frame.
REQ-002 The module SHALL have parameter NUM_COLS, default 16, meaning the number of matrix columns tracked by col_idx.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for every serial input.
REQ-004 The module SHALL have port clk, input, 1 bit: system clock.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have ports ser_clk, ser_data, ser_stcp and ser_n_enable, each input, 1 bit: asynchronous serial shift clock, data, storage latch and active-low output enable.
REQ-007 The module SHALL have port col_q, output, SPI_SIZE bits: latched storage register.
REQ-008 The module SHALL have port col_strobe, output, 1 bit: one-cycle pulse when col_q updates.
REQ-009 The module SHALL have port col_idx, output, clog2(NUM_COLS) bits: index of the currently selected column.
REQ-010 The module SHALL have port col_idx_valid, output, 1 bit: high once a first-column select has been latched.
REQ-011 The module SHALL have port extra_bit, output, 1 bit: equal to col_q[1].
REQ-012 The module SHALL have port out_en, output, 1 bit: synchronized inverse of ser_n_enable.
REQ-013 The module SHALL have ports frame_err (output, 1 bit, error pulse) and err_cnt (output, 8 bits, error count).

Function
REQ-014 Each serial input SHALL pass through SYNC_STAGES flops clocked by clk, and all further logic SHALL use only the synchronized copies.
REQ-015 A rising edge of synchronized ser_clk SHALL shift the register as shift <= {shift[SPI_SIZE-2:0], ser_data_s}, MSB first, and increment bit_cnt, saturating at 2*SPI_SIZE-1.
REQ-016 A rising edge of synchronized ser_stcp SHALL set col_q <= shift, clear bit_cnt, and pulse col_strobe on the following cycle; the shift register itself SHALL be retained.
REQ-017 When both rising edges occur in the same clk cycle, the shift SHALL take effect first and col_q SHALL capture the post-shift value.
REQ-018 The receiver FSM SHALL use states S_IDLE (bit_cnt=0), S_SHIFT (bit_cnt>0) and S_LATCH (one cycle, drives col_strobe); S_LATCH SHALL always return to S_IDLE, or to S_SHIFT if a ser_clk edge coincided.
REQ-019 On latch, when new col_q[0]==0 (active-low select first), col_idx SHALL be set to 0 and col_idx_valid to 1.
REQ-020 On latch, when new col_q[0]==1 and col_idx_valid==1, col_idx SHALL increment and wrap from NUM_COLS-1 to 0.
REQ-021 On latch, when new col_q[0]==1 and col_idx_valid==0, col_idx SHALL hold at 0.
REQ-022 out_en SHALL follow ~ser_n_enable_s with SYNC_STAGES cycles of latency, independent of the FSM.
REQ-023 Input timing SHALL be: ser_clk high and low each >= SYNC_STAGES+1 clk cycles, ser_data stable for >= SYNC_STAGES+1 cycles around each ser_clk rise, ser_stcp high >= SYNC_STAGES+1 cycles; behaviour outside these limits SHALL be undefined.
REQ-024 The latency from the ser_stcp rising pin edge to the col_strobe pulse SHALL be SYNC_STAGES+2 clk cycles.

Reset
REQ-025 Asserting rst SHALL asynchronously clear the synchronizers, shift, bit_cnt, col_q, col_idx, col_idx_valid, col_strobe, frame_err and err_cnt to 0, set the FSM to S_IDLE and drive out_en to 0.
REQ-026 When rst asserts mid-frame, the partial frame SHALL be discarded and the first ser_clk edge after release SHALL start a new frame.

Configuration
REQ-027 Macro COLUMN_RX_ERR_EN SHALL control frame checking.
REQ-028 With COLUMN_RX_ERR_EN defined, a latch with bit_cnt != SPI_SIZE SHALL pulse frame_err for one cycle, coincident with col_strobe, and increment err_cnt, saturating at 255; col_q SHALL still update.
REQ-029 With COLUMN_RX_ERR_EN undefined, frame_err and err_cnt SHALL be tied to 0, no checking logic SHALL be present, and the ports SHALL still exist.

Verification
REQ-030 Shift 8'hFE MSB first then pulse stcp -> col_q=FE, col_strobe pulses once SYNC_STAGES+2 cycles after stcp, col_idx=0, col_idx_valid=1, extra_bit=1.
REQ-031 After 8'hFE, send 16 frames of 8'hFF -> col_idx steps 1..15 then wraps to 0 on the 16th frame.
REQ-032 Frame 8'h01 sent before any first-select -> col_q=01, col_idx=0, col_idx_valid=0.
REQ-033 ser_n_enable driven 1->0 -> out_en rises after SYNC_STAGES cycles; it does not change at any latch.
REQ-034 With COLUMN_RX_ERR_EN defined, 5 bits then stcp -> frame_err pulse and err_cnt=1; 256 bad frames -> err_cnt=255; with the macro undefined, both outputs stay 0.
REQ-035 rst asserted after 4 bits, released, then a full 8'hA5 frame -> col_q=A5 and frame_err=0.
